dbg_slave_sysclk_bridge: RTL and testbench
==========================================

Name: dbg_slave_sysclk_bridge

Overview:
System-clock half of the CPU debug slave, generalised over shift-register width, IR width and command buffering.
- Synchronises the TCK-domain update strobes (vs_udr, vs_uir) into clk.
- Captures the instruction register and data shift register on each update-DR.
- Queues captured commands in a small FIFO with a valid/ready handshake.
- On each consumed command, emits one-hot take_action / take_no_action pulses indexed by instruction.
- Sits between the virtual-JTAG TCK block and the OCI break/ocimem/trace-control logic.

Parameters:
- SR_W, 38, width of data shift register / jdo.
- IR_W, 2, instruction width; NUM_IR = 2**IR_W action channels.
- ACT_BIT, 35, sr bit selecting take_action (1) vs take_no_action (0).
- SYNC_STAGES, 2, synchroniser depth (≥2).
- DEPTH, 4, command FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ir_in  in  IR_W  TCK-domain instruction; stable around vs_udr
- sr  in  SR_W  TCK-domain shift data; stable around vs_udr
- vs_udr  in  1  async update-DR level
- vs_uir  in  1  async update-IR level
- cmd_ready  in  1  consumer accepts head command
- ovf_clr  in  1  clears sticky error flags
- cmd_valid  out  1  FIFO non-empty
- cmd_ir  out  IR_W  head instruction
- jdo  out  SR_W  data of last popped command, held
- take_action  out  NUM_IR  one-cycle pulse, bit = popped ir
- take_no_action  out  NUM_IR  one-cycle pulse, bit = popped ir
- uir_pulse  out  1  one-cycle pulse per update-IR
- overflow  out  1  sticky: command dropped because FIFO was full
- parity_err  out  1  sticky: command dropped on parity (see feature)

Behaviour:
- Reset: all outputs 0, FIFO empty, synchroniser and edge registers 0.
- Async reset assert mid-operation discards queued commands immediately.
- Event detection: each strobe goes through SYNC_STAGES flops, then rising-edge detect. Event fires SYNC_STAGES+1 clk edges after the level rises. Exactly one event per rising edge; a held level gives no repeat.
- Push: on udr_evt, {ir_in, sr} is written at wptr. If full and no pop that cycle: drop, set overflow.
- Full + pop + push in the same cycle: both happen, count unchanged, no overflow.
- No bypass: a push into an empty FIFO gives cmd_valid=1 on the next cycle.
- Pop: when cmd_valid && cmd_ready. cmd_ir and head data are combinational from rptr. Popping while empty is ignored.
- Registered on pop (visible the cycle after pop):
  - jdo <= head data.
  - If head data[ACT_BIT]=1: take_action[ir]=1, else take_no_action[ir]=1.
  - All other bits 0; pulses last exactly one cycle.
- uir_evt:
  - Pulses uir_pulse for one cycle.
  - Flushes the FIFO (ptrs and count to 0). A same-cycle pop is cancelled: no action pulse.
  - uir_evt + udr_evt in the same cycle: flush first, then push; FIFO holds 1 entry.
- ovf_clr clears overflow and parity_err. A new error in the same cycle wins (flag stays 1).
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits; full = count==DEPTH.

Optional Feature:
Macro DBG_SR_PARITY_EN.
- Defined: sr[SR_W-1] is even parity over sr[SR_W-2:0], checked on udr_evt. On mismatch the command is not pushed and parity_err is set; overflow is unaffected. A parity check outranks the full check.
- Undefined: no check, all commands pushed, parity_err tied 0.

Decomposition:
- Package dbg_bridge_pkg holds:
  - the dbg_cmd_t struct {ir, data}, with widths passed via parameterised functions or localparams;
  - NUM_IR derivation;
  - an even-parity function.
- Sub-module dbg_sync_edge: SYNC_STAGES synchroniser plus rising-edge pulse, async active-low reset. Instantiated twice (udr, uir).

Test Plan:
- Single command: reset, ir_in=2'd1, sr=38'h08_0000_00AB (bit35=1), vs_udr high 4 cycles, cmd_ready=1 → cmd_valid high 3 cycles after rise for 1 cycle; next cycle take_action=4'b0010 for 1 cycle; jdo=38'h08_0000_00AB held.
- No-action path: ir_in=3, bit35=0 → take_no_action=4'b1000 pulse, take_action stays 0.
- Overflow: cmd_ready=0, 5 udr events → count=4, overflow=1. Drain → 4 pulses in push order. ovf_clr → overflow=0.
- Full with simultaneous pop+push: FIFO full, cmd_ready=1 on the udr_evt cycle → overflow stays 0, count stays 4.
- Flush: 3 queued, vs_uir rise → uir_pulse 1 cycle, cmd_valid=0 next cycle, no action pulses. Coincident udr_evt → exactly 1 entry remains.
- Parity (macro defined): sr with odd parity → no push, parity_err=1. Macro undefined → same stimulus pushes normally.

Source files
------------

// File: rtl/dbg_bridge_pkg.sv
// Shared types and helpers for the system-clock half of the CPU debug slave.
// Optional build macro: DBG_SR_PARITY_EN (even-parity check on the shift data).
package dbg_bridge_pkg;

    // Default geometry of the debug shift path.
    localparam int DEF_SR_W    = 38;
    localparam int DEF_IR_W    = 2;
    localparam int DEF_ACT_BIT = 35;

    // Widest shift register the parity helper accepts; narrower data is zero-extended.
    localparam int PAR_MAX_W = 256;

    // Command layout at the default widths. Parameterised instances declare
    // the same {ir, data} layout at their own widths.
    typedef struct packed {
        logic [DEF_IR_W-1:0] ir;
        logic [DEF_SR_W-1:0] data;
    } dbg_cmd_t;

    // Number of one-hot action channels for a given instruction width.
    function automatic int num_ir(input int ir_w);
        return 1 << ir_w;
    endfunction

    // Even-parity bit: makes the total number of ones (data + bit) even.
    // Zero-extension does not change the result.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/dbg_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a rising-edge
// detector. pulse_o is high for exactly one clk cycle per rising edge of async_i.
module dbg_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // Shift the async level through the synchroniser and keep the last synced value.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Pulse is decoded from flops only, so it is glitch-free and acts on the next edge.
    assign pulse_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/dbg_slave_sysclk_bridge.sv
// System-clock half of the CPU debug slave: synchronises the TCK-domain
// update strobes, queues {ir, sr} commands in a small FIFO and emits one-hot
// take_action / take_no_action pulses as commands are consumed.
// Optional build macro: DBG_SR_PARITY_EN -- when defined, sr[SR_W-1] must be
// even parity over sr[SR_W-2:0] or the command is dropped and parity_err set.
module dbg_slave_sysclk_bridge
    import dbg_bridge_pkg::*;
#(
    parameter  int SR_W        = DEF_SR_W,
    parameter  int IR_W        = DEF_IR_W,
    parameter  int ACT_BIT     = DEF_ACT_BIT,
    parameter  int SYNC_STAGES = 2,
    parameter  int DEPTH       = 4,
    localparam int NUM_IR      = num_ir(IR_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [SR_W-1:0]   sr,
    input  logic              vs_udr,
    input  logic              vs_uir,
    input  logic              cmd_ready,
    input  logic              ovf_clr,
    output logic              cmd_valid,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [SR_W-1:0]   jdo,
    output logic [NUM_IR-1:0] take_action,
    output logic [NUM_IR-1:0] take_no_action,
    output logic              uir_pulse,
    output logic              overflow,
    output logic              parity_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [NUM_IR-1:0] ONE_HOT0 = NUM_IR'(1);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } cmd_t;

    cmd_t              mem_q [DEPTH];
    cmd_t              head;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, wr_addr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              udr_evt, uir_evt;
    logic              full, pop, push, parity_ok, ovf_set, par_set;
    logic [SR_W-1:0]   jdo_q;
    logic [NUM_IR-1:0] take_action_q, take_no_action_q;
    logic              overflow_q;

    dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (vs_udr),
        .pulse_o (udr_evt)
    );

    dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (vs_uir),
        .pulse_o (uir_evt)
    );

`ifdef DBG_SR_PARITY_EN
    assign parity_ok = (sr[SR_W-1] == even_parity(PAR_MAX_W'(sr[SR_W-2:0])));
`else
    assign parity_ok = 1'b1;
`endif

    // Handshake and FIFO control. A flush cancels a same-cycle pop and frees
    // room for a same-cycle push; a pop makes room for a push into a full FIFO.
    assign cmd_valid = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign head      = mem_q[rptr_q];
    assign cmd_ir    = head.ir;
    assign pop       = cmd_valid && cmd_ready && !uir_evt;
    assign push      = udr_evt && parity_ok && (uir_evt || !full || pop);
    assign ovf_set   = udr_evt && parity_ok && !uir_evt && full && !pop;
    assign par_set   = udr_evt && !parity_ok;
    assign wr_addr   = uir_evt ? '0 : wptr_q;

    // Next-state for pointers and occupancy count.
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (uir_evt) begin
            rptr_d  = '0;
            wptr_d  = push ? PTR_W'(1) : '0;
            count_d = push ? CNT_W'(1) : '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO storage write port.
    // NOTE: the command array is deliberately not reset; emptiness is tracked by
    // count_q, so stale contents are never observable and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_addr] <= '{ir: ir_in, data: sr};
    end

    // Pointer, count and registered output state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q           <= '0;
            rptr_q           <= '0;
            count_q          <= '0;
            jdo_q            <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overflow_q       <= 1'b0;
        end else begin
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            count_q          <= count_d;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            if (pop) begin
                jdo_q <= head.data;
                if (head.data[ACT_BIT]) take_action_q    <= ONE_HOT0 << head.ir;
                else                    take_no_action_q <= ONE_HOT0 << head.ir;
            end
            overflow_q <= ovf_set | (overflow_q & ~ovf_clr);
        end
    end

`ifdef DBG_SR_PARITY_EN
    logic parity_err_q;

    // Sticky parity error; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) parity_err_q <= 1'b0;
        else          parity_err_q <= par_set | (parity_err_q & ~ovf_clr);
    end

    assign parity_err = parity_err_q;
`else
    logic unused_par;
    assign unused_par = par_set;
    assign parity_err = 1'b0;
`endif

    assign jdo            = jdo_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign overflow       = overflow_q;
    assign uir_pulse      = uir_evt;

endmodule

// File: tb/tb_dbg_slave_sysclk_bridge.sv
// Directed self-checking bench for dbg_slave_sysclk_bridge (default geometry).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dbg_slave_sysclk_bridge;

    localparam int SR_W   = 38;
    localparam int IR_W   = 2;
    localparam int NUM_IR = 4;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } cmd_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [IR_W-1:0]   ir_in;
    logic [SR_W-1:0]   sr;
    logic              vs_udr, vs_uir, cmd_ready, ovf_clr;
    logic              cmd_valid;
    logic [IR_W-1:0]   cmd_ir;
    logic [SR_W-1:0]   jdo;
    logic [NUM_IR-1:0] take_action, take_no_action;
    logic              uir_pulse, overflow, parity_err;

    int   checks = 0;
    int   errors = 0;
    cmd_t exp_q[$];

    always #5 clk = ~clk;

    dbg_slave_sysclk_bridge dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ir_in          (ir_in),
        .sr             (sr),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .cmd_ready      (cmd_ready),
        .ovf_clr        (ovf_clr),
        .cmd_valid      (cmd_valid),
        .cmd_ir         (cmd_ir),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .uir_pulse      (uir_pulse),
        .overflow       (overflow),
        .parity_err     (parity_err)
    );

    // Sets bit 37 to even parity over bits 36:0 so commands pass the optional check.
    function automatic logic [SR_W-1:0] fix_par(input logic [SR_W-1:0] d);
        logic [SR_W-1:0] r;
        r = d;
        r[SR_W-1] = ^d[SR_W-2:0];
        return r;
    endfunction

    // Raise vs_udr for 4 cycles then hold it low 3 cycles; the push lands on the
    // 3rd rising edge. With pop_at_push, cmd_ready is high only for that edge.
    task automatic send_cmd(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d,
                            input bit pop_at_push);
        ir_in  = ir;
        sr     = d;
        vs_udr = 1'b1;
        repeat (2) @(negedge clk);
        if (pop_at_push) cmd_ready = 1'b1;
        @(negedge clk);
        if (pop_at_push) cmd_ready = 1'b0;
        @(negedge clk);
        vs_udr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Pop n commands back to back and compare each against the expected queue.
    task automatic drain(input string name, input int n);
        cmd_t              h;
        logic [NUM_IR-1:0] exp_ta, exp_tn;
        cmd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            h = exp_q.pop_front();
            checks++;
            if (cmd_ir !== h.ir) begin
                errors++;
                $display("FAIL %s_cmd_ir[%0d]: got %0d expected %0d", name, i, cmd_ir, h.ir);
            end
            @(negedge clk);
            exp_ta = h.data[35] ? (4'b0001 << h.ir) : 4'b0000;
            exp_tn = h.data[35] ? 4'b0000 : (4'b0001 << h.ir);
            checks++;
            if ({take_action, take_no_action, jdo} !== {exp_ta, exp_tn, h.data}) begin
                errors++;
                $display("FAIL %s_pop[%0d]: got ta=%b tn=%b jdo=%h expected ta=%b tn=%b jdo=%h",
                         name, i, take_action, take_no_action, jdo, exp_ta, exp_tn, h.data);
            end
        end
        cmd_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_valid, take_action, take_no_action} !== 9'b0) begin
            errors++;
            $display("FAIL %s_empty: got valid=%b ta=%b tn=%b expected all 0",
                     name, cmd_valid, take_action, take_no_action);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0;
        cmd_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_valid, jdo, take_action, take_no_action, uir_pulse, overflow, parity_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b jdo=%h ta=%b tn=%b uir=%b ovf=%b par=%b expected all 0",
                     cmd_valid, jdo, take_action, take_no_action, uir_pulse, overflow, parity_err);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single(input string name, input logic [IR_W-1:0] ir,
                               input logic [SR_W-1:0] d,
                               input logic [NUM_IR-1:0] ta, input logic [NUM_IR-1:0] tn);
        cmd_ready = 1'b1; ir_in = ir; sr = d; vs_udr = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) vs_udr = 1'b0;
            checks++;
            if (cmd_valid !== (k == 3)) begin
                errors++;
                $display("FAIL %s_valid[k=%0d]: got %b expected %b", name, k, cmd_valid, (k == 3));
            end
            checks++;
            if ({take_action, take_no_action} !== ((k == 4) ? {ta, tn} : 8'b0)) begin
                errors++;
                $display("FAIL %s_pulse[k=%0d]: got ta=%b tn=%b", name, k, take_action, take_no_action);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (jdo !== d) begin
            errors++;
            $display("FAIL %s_jdo_held: got %h expected %h", name, jdo, d);
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [IR_W-1:0] irs [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [SR_W-1:0] ds  [5] = '{38'h08_0000_0011, 38'h00_0000_0022, 38'h08_0000_0033,
                                     38'h00_0000_0044, 38'h08_0000_0055};
        cmd_t c;
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c = '{ir: irs[i], data: fix_par(ds[i])};
            send_cmd(c.ir, c.data, 1'b0);
            if (i < 4) exp_q.push_back(c);
            if (i == 3) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_at_four: got %b expected 0", overflow);
                end
            end
        end
        checks++;
        if ({overflow, cmd_valid} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%b valid=%b expected 1 1", overflow, cmd_valid);
        end
        drain("ovf", 4);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b expected 0", overflow);
        end
    endtask

    task automatic test_full_pop_push();
        cmd_t c, popped;
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c = '{ir: IR_W'(i), data: fix_par(38'h00_0000_0100 + 38'(i))};
            send_cmd(c.ir, c.data, 1'b0);
            exp_q.push_back(c);
        end
        c = '{ir: 2'd3, data: fix_par(38'h08_0000_0ABC)};
        send_cmd(c.ir, c.data, 1'b1);
        popped = exp_q.pop_front();
        exp_q.push_back(c);
        checks++;
        if ({overflow, jdo} !== {1'b0, popped.data}) begin
            errors++;
            $display("FAIL fullpp: got ovf=%b jdo=%h expected ovf=0 jdo=%h", overflow, jdo, popped.data);
        end
        drain("fullpp", 4);
    endtask

    task automatic test_flush();
        cmd_t c;
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_cmd(IR_W'(i), fix_par(38'h08_0000_0200 + 38'(i)), 1'b0);
        vs_uir = 1'b1;
        @(negedge clk);
        checks++;
        if (uir_pulse !== 1'b0) begin
            errors++;
            $display("FAIL flush_early: got uir_pulse=%b expected 0", uir_pulse);
        end
        @(negedge clk);
        checks++;
        if ({uir_pulse, cmd_valid} !== 2'b11) begin
            errors++;
            $display("FAIL flush_pulse: got uir=%b valid=%b expected 1 1", uir_pulse, cmd_valid);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        checks++;
        if ({uir_pulse, cmd_valid, take_action, take_no_action} !== 10'b0) begin
            errors++;
            $display("FAIL flush_after: got uir=%b valid=%b ta=%b tn=%b expected all 0",
                     uir_pulse, cmd_valid, take_action, take_no_action);
        end
        vs_uir = 1'b0;
        repeat (3) @(negedge clk);
        // Coincident flush and push: only the new command survives.
        for (int i = 0; i < 2; i++) send_cmd(IR_W'(i), fix_par(38'h00_0000_0300 + 38'(i)), 1'b0);
        c = '{ir: 2'd2, data: fix_par(38'h08_0000_0777)};
        ir_in = c.ir; sr = c.data; vs_udr = 1'b1; vs_uir = 1'b1;
        repeat (4) @(negedge clk);
        vs_udr = 1'b0; vs_uir = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_q.push_back(c);
        drain("flushpush", 1);
    endtask

    task automatic test_async_reset();
        cmd_ready = 1'b0;
        for (int i = 0; i < 2; i++) send_cmd(IR_W'(i), fix_par(38'h08_0000_0400 + 38'(i)), 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b expected 0", cmd_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_release: got valid=%b expected 0", cmd_valid);
        end
    endtask

    task automatic test_parity();
        // Bits 36:0 hold a single one and bit 37 is 0: odd parity.
        cmd_t c;
        c = '{ir: 2'd2, data: 38'h00_0000_0001};
        cmd_ready = 1'b0;
        send_cmd(c.ir, c.data, 1'b0);
`ifdef DBG_SR_PARITY_EN
        checks++;
        if ({parity_err, cmd_valid, overflow} !== 3'b100) begin
            errors++;
            $display("FAIL parity_drop: got par=%b valid=%b ovf=%b expected 1 0 0",
                     parity_err, cmd_valid, overflow);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (parity_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_clr: got %b expected 0", parity_err);
        end
`else
        checks++;
        if ({parity_err, cmd_valid} !== 2'b01) begin
            errors++;
            $display("FAIL parity_off: got par=%b valid=%b expected 0 1", parity_err, cmd_valid);
        end
        exp_q.push_back(c);
        drain("parity_off", 1);
`endif
    endtask

    initial begin
        test_reset();
        test_single("single", 2'd1, 38'h08_0000_00AB, 4'b0010, 4'b0000);
        test_single("noact", 2'd3, fix_par(38'h00_1234_5678), 4'b0000, 4'b1000);
        test_overflow();
        test_full_pop_push();
        test_flush();
        test_async_reset();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
